msf_frame_decoder: RTL and testbench

MSF_FRAME_DECODER -- requirements
Module: msf_frame_decoder

---
 rtl/msf_frame_decoder.sv | 166 ++++++++++++++++
 tb/tb_msf_frame_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msf_frame_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// msf_frame_decoder
//   Collects one MSF minute frame (A/B bits of seconds 01..59), validates it
//   and presents the BCD date/time on a one-cycle load pulse.
//   Revision: 1.0
// ============================================================================
module msf_frame_decoder #(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       minute_mark_i,
  input  logic       sec_valid_i,
  input  logic       bit_a_i,
  input  logic       bit_b_i,
  output logic       load_o,
  output logic [3:0] year_h_o,
  output logic [3:0] year_l_o,
  output logic       month_h_o,
  output logic [3:0] month_l_o,
  output logic [1:0] day_h_o,
  output logic [3:0] day_l_o,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] minute_h_o,
  output logic [3:0] minute_l_o,
  output logic [2:0] second_h_o,
  output logic [3:0] second_l_o,
  output logic       sync_o,
  output logic       frame_err_o
);

  typedef enum logic [0:0] {SEARCH = 1'b0, COLLECT = 1'b1} state_e;

  localparam logic [5:0] LAST_IDX = 6'd59;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d, idx_inc;
  logic [17:51] a_q, a_d;
  logic [54:57] b_q, b_d;
  logic        load_q, load_d;
  logic        frame_err_q, frame_err_d;
  logic        sync_q, sync_d;
  logic [31:0] fields_q, fields_d;

  logic [3:0]  year_h, year_l, month_l, day_l, hour_l, minute_l;
  logic        month_h;
  logic [1:0]  day_h, hour_h;
  logic [2:0]  minute_h;
  logic        parity_ok, range_ok, frame_ok;

  // A-bit positions map MSB-first onto each BCD digit
  assign year_h   = a_q[17:20];
  assign year_l   = a_q[21:24];
  assign month_h  = a_q[25];
  assign month_l  = a_q[26:29];
  assign day_h    = a_q[30:31];
  assign day_l    = a_q[32:35];
  assign hour_h   = a_q[39:40];
  assign hour_l   = a_q[41:44];
  assign minute_h = a_q[45:47];
  assign minute_l = a_q[48:51];

  assign parity_ok = !CHECK_PARITY ||
                     ((^{a_q[17:24], b_q[54]}) && (^{a_q[25:35], b_q[55]}) &&
                      (^{a_q[36:38], b_q[56]}) && (^{a_q[39:51], b_q[57]}));

  assign range_ok = (year_h <= 4'd9) && (year_l <= 4'd9) && (month_l <= 4'd9) &&
                    (day_l <= 4'd9) && (hour_l <= 4'd9) && (minute_l <= 4'd9) &&
                    (month_h ? (month_l <= 4'd2) : (month_l != 4'd0)) &&
                    ((day_h != 2'd0) || (day_l != 4'd0)) &&
                    ((day_h != 2'd3) || (day_l <= 4'd1)) &&
                    (hour_h != 2'd3) && ((hour_h != 2'd2) || (hour_l <= 4'd3)) &&
                    (minute_h <= 3'd5);

  assign frame_ok = (idx_q == LAST_IDX) && parity_ok && range_ok;
  assign idx_inc  = idx_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    load_d      = 1'b0;
    frame_err_d = 1'b0;
    sync_d      = sync_q;
    fields_d    = fields_q;
    unique case (state_q)
      SEARCH: begin
        if (minute_mark_i) begin
          state_d = COLLECT;
          idx_d   = '0;
          a_d     = '0;
          b_d     = '0;
        end
      end
      COLLECT: begin
        if (minute_mark_i) begin
          idx_d = '0;
          a_d   = '0;
          b_d   = '0;
          if (frame_ok) begin
            load_d   = 1'b1;
            sync_d   = 1'b1;
            fields_d = {year_h, year_l, month_h, month_l, day_h, day_l,
                        hour_h, hour_l, minute_h, minute_l};
          end else begin
            frame_err_d = 1'b1;
            sync_d      = 1'b0;
          end
        end else if (sec_valid_i) begin
          if (idx_q == LAST_IDX) begin
            frame_err_d = 1'b1;
            sync_d      = 1'b0;
            state_d     = SEARCH;
            idx_d       = '0;
          end else begin
            idx_d = idx_inc;
            for (int k = 17; k <= 51; k++) begin
              if (idx_inc == 6'(k)) a_d[k] = bit_a_i;
            end
            for (int k = 54; k <= 57; k++) begin
              if (idx_inc == 6'(k)) b_d[k] = bit_b_i;
            end
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= SEARCH;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      load_q      <= 1'b0;
      frame_err_q <= 1'b0;
      sync_q      <= 1'b0;
      fields_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      load_q      <= load_d;
      frame_err_q <= frame_err_d;
      sync_q      <= sync_d;
      fields_q    <= fields_d;
    end
  end

  assign load_o      = load_q;
  assign frame_err_o = frame_err_q;
  assign sync_o      = sync_q;
  assign {year_h_o, year_l_o, month_h_o, month_l_o, day_h_o, day_l_o,
          hour_h_o, hour_l_o, minute_h_o, minute_l_o} = fields_q;
  // A load always happens on the minute boundary, so seconds read 00
  assign second_h_o  = 3'd0;
  assign second_l_o  = 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_msf_frame_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_msf_frame_decoder
//   Randomised frame stimulus against an integer-level model, for the
//   parity-checking and parity-ignoring variants side by side.
//   Revision: 1.0
// ============================================================================
module tb_msf_frame_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, mm, sv, ba, bb;

  logic [1:0]      d_load, d_sync, d_err, d_moh;
  logic [1:0][3:0] d_yh, d_yl, d_mol, d_dl, d_hl, d_mil, d_sl;
  logic [1:0][1:0] d_dh, d_hh;
  logic [1:0][2:0] d_mih, d_sh;

  msf_frame_decoder #(.CHECK_PARITY(1'b1)) dut_p1 (
    .clk_i(clk), .rst_ni(rst_n), .minute_mark_i(mm), .sec_valid_i(sv),
    .bit_a_i(ba), .bit_b_i(bb), .load_o(d_load[0]),
    .year_h_o(d_yh[0]), .year_l_o(d_yl[0]), .month_h_o(d_moh[0]), .month_l_o(d_mol[0]),
    .day_h_o(d_dh[0]), .day_l_o(d_dl[0]), .hour_h_o(d_hh[0]), .hour_l_o(d_hl[0]),
    .minute_h_o(d_mih[0]), .minute_l_o(d_mil[0]), .second_h_o(d_sh[0]), .second_l_o(d_sl[0]),
    .sync_o(d_sync[0]), .frame_err_o(d_err[0]));

  msf_frame_decoder #(.CHECK_PARITY(1'b0)) dut_p0 (
    .clk_i(clk), .rst_ni(rst_n), .minute_mark_i(mm), .sec_valid_i(sv),
    .bit_a_i(ba), .bit_b_i(bb), .load_o(d_load[1]),
    .year_h_o(d_yh[1]), .year_l_o(d_yl[1]), .month_h_o(d_moh[1]), .month_l_o(d_mol[1]),
    .day_h_o(d_dh[1]), .day_l_o(d_dl[1]), .hour_h_o(d_hh[1]), .hour_l_o(d_hl[1]),
    .minute_h_o(d_mih[1]), .minute_l_o(d_mil[1]), .second_h_o(d_sh[1]), .second_l_o(d_sl[1]),
    .sync_o(d_sync[1]), .frame_err_o(d_err[1]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [38:0] act_f(input int k);
    return {d_yh[k], d_yl[k], d_moh[k], d_mol[k], d_dh[k], d_dl[k],
            d_hh[k], d_hl[k], d_mih[k], d_mil[k], d_sh[k], d_sl[k]};
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_collect;
  int          m_cnt;
  bit          m_a[1:59];
  bit          m_b[1:59];
  bit          m_load[2], m_err[2], m_sync[2];
  logic [38:0] m_f[2];
  bit          exp_load[2], exp_err[2], exp_sync[2];
  logic [38:0] exp_f[2];

  function automatic int val(input int lo, input int w);
    int v = 0;
    for (int i = 0; i < w; i++) v = v * 2 + int'(m_a[lo + i]);
    return v;
  endfunction

  function automatic bit odd_grp(input int lo, input int hi, input int bpos);
    int c = int'(m_b[bpos]);
    for (int i = lo; i <= hi; i++) c += int'(m_a[i]);
    return (c % 2) == 1;
  endfunction

  task automatic model_clear();
    for (int i = 1; i <= 59; i++) begin
      m_a[i] = 1'b0;
      m_b[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_collect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_load[k] = 1'b0; m_err[k] = 1'b0; m_sync[k] = 1'b0; m_f[k] = '0;
    end
  endtask

  task automatic model_eval();
    int yh, yl, moh, mol, dh, dl, hh, hl, mih, mil, month, day, hour;
    bit rng, par;
    yh = val(17, 4); yl = val(21, 4); moh = val(25, 1); mol = val(26, 4);
    dh = val(30, 2); dl = val(32, 4); hh = val(39, 2); hl = val(41, 4);
    mih = val(45, 3); mil = val(48, 4);
    month = 10 * moh + mol;
    day   = 10 * dh + dl;
    hour  = 10 * hh + hl;
    rng = (m_cnt == 59) && yh <= 9 && yl <= 9 && mol <= 9 && dl <= 9 && hl <= 9 &&
          mil <= 9 && month >= 1 && month <= 12 && day >= 1 && day <= 31 &&
          hour <= 23 && mih <= 5;
    par = odd_grp(17, 24, 54) && odd_grp(25, 35, 55) &&
          odd_grp(36, 38, 56) && odd_grp(39, 51, 57);
    for (int k = 0; k < 2; k++) begin
      if (rng && (par || k == 1)) begin
        m_load[k] = 1'b1;
        m_sync[k] = 1'b1;
        m_f[k] = {4'(yh), 4'(yl), 1'(moh), 4'(mol), 2'(dh), 4'(dl),
                  2'(hh), 4'(hl), 3'(mih), 4'(mil), 3'd0, 4'd0};
      end else begin
        m_err[k]  = 1'b1;
        m_sync[k] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input bit mm_v, input bit sv_v, input bit a_v, input bit b_v);
    for (int k = 0; k < 2; k++) begin
      m_load[k] = 1'b0;
      m_err[k]  = 1'b0;
    end
    if (mm_v) begin
      if (m_collect) model_eval();
      m_collect = 1'b1;
      model_clear();
    end else if (sv_v && m_collect) begin
      if (m_cnt == 59) begin
        for (int k = 0; k < 2; k++) begin
          m_err[k]  = 1'b1;
          m_sync[k] = 1'b0;
        end
        m_collect = 1'b0;
        m_cnt = 0;
      end else begin
        m_cnt++;
        m_a[m_cnt] = a_v;
        m_b[m_cnt] = b_v;
      end
    end
  endtask

  task automatic snap();
    for (int k = 0; k < 2; k++) begin
      exp_load[k] = m_load[k];
      exp_err[k]  = m_err[k];
      exp_sync[k] = m_sync[k];
      exp_f[k]    = m_f[k];
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("load[%0d]", k), 64'(d_load[k]), 64'(exp_load[k]));
        check($sformatf("frame_err[%0d]", k), 64'(d_err[k]), 64'(exp_err[k]));
        check($sformatf("sync[%0d]", k), 64'(d_sync[k]), 64'(exp_sync[k]));
        check($sformatf("fields[%0d]", k), 64'(act_f(k)), 64'(exp_f[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  bit fa[0:63];
  bit fb[0:63];

  task automatic do_cycle(input bit mm_v, input bit sv_v, input bit a_v, input bit b_v);
    mm = mm_v; sv = sv_v; ba = a_v; bb = b_v;
    model_step(mm_v, sv_v, a_v, b_v);
    @(posedge clk);
    #1;
    snap();
    mm = 1'b0; sv = 1'b0; ba = 1'b0; bb = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    snap();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic put(input int lo, input int w, input int v);
    for (int i = 0; i < w; i++) fa[lo + i] = bit'((v >> (w - 1 - i)) & 1);
  endtask

  function automatic bit even_ones(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(fa[i]);
    return (c % 2) == 0;
  endfunction

  task automatic set_frame(input int yy, input int mo, input int dd, input int hh, input int mi);
    for (int i = 0; i <= 63; i++) begin
      fa[i] = 1'($urandom_range(0, 1));
      fb[i] = 1'($urandom_range(0, 1));
    end
    put(17, 4, yy / 10); put(21, 4, yy % 10);
    put(25, 1, mo / 10); put(26, 4, mo % 10);
    put(30, 2, dd / 10); put(32, 4, dd % 10);
    put(39, 2, hh / 10); put(41, 4, hh % 10);
    put(45, 3, mi / 10); put(48, 4, mi % 10);
    fb[54] = even_ones(17, 24);
    fb[55] = even_ones(25, 35);
    fb[56] = even_ones(36, 38);
    fb[57] = even_ones(39, 51);
  endtask

  task automatic send_secs(input int n);
    for (int s = 1; s <= n; s++) begin
      if ($urandom_range(0, 3) == 0) do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b0, 1'b1, fa[s], fb[s]);
    end
  endtask

  task automatic marker(input bit rand_sv);
    bit s;
    s = rand_sv ? 1'($urandom_range(0, 1)) : 1'b0;
    do_cycle(1'b1, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, len;
    rst_n = 1'b0; mm = 1'b0; sv = 1'b0; ba = 1'b0; bb = 1'b0;
    model_reset();
    snap();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_sync", 64'(d_sync[0]), 64'd0);
    check("rst_year_l", 64'(d_yl[0]), 64'd0);
    repeat (2) do_cycle(1'b0, 1'b1, 1'b1, 1'b1);

    // first marker only opens a frame
    marker(1'b0);
    check("first_mark_load", 64'(d_load[0]), 64'd0);
    check("first_mark_err", 64'(d_err[0]), 64'd0);

    // 23-06-15 14:37
    set_frame(23, 6, 15, 14, 37);
    send_secs(59);
    marker(1'b0);
    check("good_load", 64'(d_load[0]), 64'd1);
    check("good_year_h", 64'(d_yh[0]), 64'd2);
    check("good_year_l", 64'(d_yl[0]), 64'd3);
    check("good_month_h", 64'(d_moh[0]), 64'd0);
    check("good_month_l", 64'(d_mol[0]), 64'd6);
    check("good_day_h", 64'(d_dh[0]), 64'd1);
    check("good_day_l", 64'(d_dl[0]), 64'd5);
    check("good_hour_h", 64'(d_hh[0]), 64'd1);
    check("good_hour_l", 64'(d_hl[0]), 64'd4);
    check("good_min_h", 64'(d_mih[0]), 64'd3);
    check("good_min_l", 64'(d_mil[0]), 64'd7);
    check("good_sec", 64'({d_sh[0], d_sl[0]}), 64'd0);
    check("good_sync", 64'(d_sync[0]), 64'd1);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // B55 inverted
    fb[55] = ~fb[55];
    send_secs(59);
    marker(1'b0);
    check("par_err", 64'(d_err[0]), 64'd1);
    check("par_noload", 64'(d_load[0]), 64'd0);
    check("par_sync", 64'(d_sync[0]), 64'd0);
    check("par_hold_year_l", 64'(d_yl[0]), 64'd3);
    check("nopar_load", 64'(d_load[1]), 64'd1);

    // short frame, then a full one proves idx restarted
    set_frame(23, 6, 15, 14, 37);
    send_secs(58);
    marker(1'b0);
    check("short_err", 64'(d_err[0]), 64'd1);
    check("short_noload", 64'(d_load[0]), 64'd0);
    send_secs(59);
    marker(1'b0);
    check("after_short_load", 64'(d_load[0]), 64'd1);

    // 60 seconds with no marker
    send_secs(60);
    check("overrun_err", 64'(d_err[0]), 64'd1);
    check("overrun_sync", 64'(d_sync[0]), 64'd0);
    marker(1'b0);
    check("search_mark_load", 64'(d_load[0]), 64'd0);
    check("search_mark_err", 64'(d_err[0]), 64'd0);

    // out-of-range fields with correct parity
    set_frame(23, 13, 15, 14, 37);
    send_secs(59);
    marker(1'b0);
    check("month13_err_p1", 64'(d_err[0]), 64'd1);
    check("month13_err_p0", 64'(d_err[1]), 64'd1);
    set_frame(23, 6, 15, 24, 37);
    send_secs(59);
    marker(1'b0);
    check("hour24_err", 64'(d_err[0]), 64'd1);

    // reset mid-frame
    set_frame(99, 12, 31, 23, 59);
    send_secs(30);
    do_reset(2);
    marker(1'b0);
    check("post_rst_mark_load", 64'(d_load[0]), 64'd0);
    send_secs(59);
    marker(1'b0);
    check("post_rst_load", 64'(d_load[0]), 64'd1);
    check("post_rst_year_h", 64'(d_yh[0]), 64'd9);

    // randomised frames
    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 9));
      set_frame(int'($urandom_range(0, 99)), int'($urandom_range(1, 12)),
                int'($urandom_range(1, 31)), int'($urandom_range(0, 23)),
                int'($urandom_range(0, 59)));
      len = 59;
      case (mode)
        6: begin
          len = int'($urandom_range(17, 51));
          fa[len] = ~fa[len];
          len = 59;
        end
        7: for (int i = 17; i <= 57; i++) fa[i] = 1'($urandom_range(0, 1));
        8: len = int'($urandom_range(56, 60));
        9: begin
          len = int'($urandom_range(54, 57));
          fb[len] = ~fb[len];
          len = 59;
        end
        default: ;
      endcase
      send_secs(len);
      marker(1'b1);
    end

    repeat (3) do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
